oc_tick_timer: RTL and testbench
================================

// Module: oc_tick_timer
// PURPOSE
//  Consumer of the chip status real-time ticks (tick1us/tick1ms/tick1s).
//  Gives user logic a programmable one-shot/periodic countdown timer in us, ms or s units.
//  Also checks the incoming tick stream, flagging a tick1us period or tick alignment fault.
//  Sits beside user blocks that receive chipStatus from the chip status generator.
// PARAMETERS
//  ClockHz     100_000_000  clock frequency; sets the expected tick1us period
//  CountWidth  32           width of load value and countdown counter
// PORTS
//  clock          in   1           single clock; ticks are synchronous to it
//  resetN         in   1           asynchronous, active-low reset
//  chipStatus     in   chip_status_s  oclib_pkg::chip_status_s; only tick1us/1ms/1s used
//  cfgUnit        in   2           0=us 1=ms 2=s 3=reserved (treated as us)
//  cfgPeriodic    in   1           1=reload on expiry, 0=one-shot
//  cfgLoad        in   CountWidth  countdown value, in units
//  start          in   1           1-cycle pulse: load and run
//  stop           in   1           1-cycle pulse: halt, hold count
//  tickErrorClear in   1           clears tickError
//  running        out  1           timer in RUN state
//  count          out  CountWidth  current remaining units
//  expire         out  1           1-cycle pulse on reaching zero
//  tickError      out  1           sticky tick-stream fault
// BEHAVIOUR
//  Reset values: running=0, count=0, expire=0, tickError=0, state=IDLE.
//  Edge detect: each tick bit is stretched over several cycles, so tickQ<=tick each clock.
//  - rise = tick & ~tickQ, combinational. No synchronizer is needed.
//  - unitRise = rise of the unit latched at start; cfgUnit is ignored while running.
//  FSM IDLE/RUN. Priority in a cycle: stop > start > unitRise.
//  - IDLE+start, cfgLoad!=0: count<=cfgLoad, latch unit/periodic, go RUN.
//  - IDLE+start, cfgLoad==0: expire=1 next cycle, stay IDLE, count=0.
//  - RUN+unitRise, count>1: count<=count-1.
//  - RUN+unitRise, count==1, periodic: count<=cfgLoad (sampled now), expire next cycle, stay RUN.
//  - Periodic reload with cfgLoad==0: count<=0, go IDLE, expire still pulses.
//  - RUN+unitRise, count==1, one-shot: count<=0, go IDLE, expire next cycle.
//  - RUN+start: restart with cfgLoad; the same-cycle tick is dropped; no expire.
//  - stop in any state: go IDLE and hold count; a simultaneous start or tick is ignored.
//  Latency: tick rises in cycle N, count updates at edge N+1, expire is high during N+1 only.
//  running equals (state==RUN), registered.
//  Checker: UsNom = ClockHz/1_000_000, 16-bit saturating clock counter.
//  - The counter resets to 1 on tick1us rise, otherwise increments.
//  - On each tick1us rise after the first one since reset, interval must be UsNom or UsNom+1.
//  - Any other interval sets tickError.
//  - tick1ms rise without a same-cycle tick1us rise sets tickError; same rule for tick1s vs tick1ms.
//  - tickErrorClear clears tickError; a same-cycle new error wins (stays 1).
//  - Counter saturation is treated as an error if a tick1us rise is then seen.
//  Async reset mid-run: all state returns to reset values immediately; first interval re-ignored.
// TESTING
//  Stimulus uses ClockHz=100M and an ideal tick model (us period 100 clocks, high 5 cycles).
//  - unit=us, load=3, one-shot, start -> 3 us rises later expire pulses 1 cycle, running->0, count=0.
//  - unit=ms, load=2, periodic -> expire every 2000 us rises, count reloads to 2 each time.
//  - start with load=0 -> expire next cycle, running stays 0.
//  - stop and a tick rise in the same cycle, count=5 -> IDLE, count=5, no expire.
//  - start while running (count=7, load=9) with a tick that cycle -> count=9, no expire.
//  - Interval 102 clocks, then tick1ms without tick1us -> tickError=1; clear -> 0; intervals of 100/101 -> stays 0.
//  - resetN low mid-run -> all outputs 0 asynchronously; first post-reset interval is not checked.

Source files
------------

// File: rtl/oc_tick_timer_if.sv
// Control/status bundle between user logic and oc_tick_timer.
// The user side drives configuration and pulses; the timer drives status back.
interface oc_tick_timer_if #(
    parameter int CountWidth = 32
);
    logic [1:0]            cfgUnit;
    logic                  cfgPeriodic;
    logic [CountWidth-1:0] cfgLoad;
    logic                  start;
    logic                  stop;
    logic                  tickErrorClear;
    logic                  running;
    logic [CountWidth-1:0] count;
    logic                  expire;
    logic                  tickError;

    modport master (
        output cfgUnit, cfgPeriodic, cfgLoad, start, stop, tickErrorClear,
        input  running, count, expire, tickError
    );

    modport slave (
        input  cfgUnit, cfgPeriodic, cfgLoad, start, stop, tickErrorClear,
        output running, count, expire, tickError
    );
endinterface

// File: rtl/oc_tick_timer.sv
// Programmable us/ms/s countdown timer driven by the chip status real-time ticks,
// with a monitor that flags a malformed tick1us period or misaligned ms/s ticks.
package oclib_pkg;
    typedef struct packed {
        logic tick1s;
        logic tick1ms;
        logic tick1us;
    } chip_status_s;
endpackage

module oc_tick_timer #(
    parameter int ClockHz    = 100_000_000,
    parameter int CountWidth = 32
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  oclib_pkg::chip_status_s  chipStatus,
    oc_tick_timer_if.slave           tmr
);
    localparam int                    UsNomInt = ClockHz / 1_000_000;
    localparam logic [15:0]           UsNom    = 16'(UsNomInt);
    localparam logic [15:0]           UsNomP1  = 16'(UsNomInt + 1);
    localparam logic [15:0]           CntMax   = 16'hFFFF;
    localparam logic [CountWidth-1:0] One      = CountWidth'(1);

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    logic [2:0]            tick_s;
    logic [2:0]            tickQ_r;
    logic [2:0]            rise_s;
    logic                  unitRise_s;
    logic                  loadZero_s;

    state_e                state_r;
    state_e                stateNext_s;
    logic [1:0]            unit_r;
    logic [1:0]            unitNext_s;
    logic                  periodic_r;
    logic                  periodicNext_s;
    logic [CountWidth-1:0] count_r;
    logic [CountWidth-1:0] countNext_s;
    logic                  expire_r;
    logic                  expireNext_s;
    logic                  running_r;

    logic [15:0]           usCnt_r;
    logic [15:0]           usCntNext_s;
    logic                  usSeen_r;
    logic                  intervalBad_s;
    logic                  alignBad_s;
    logic                  tickError_r;
    logic                  tickErrorNext_s;

    // Ticks are already synchronous and stretched, so a single delay stage gives clean edges.
    assign tick_s     = {chipStatus.tick1s, chipStatus.tick1ms, chipStatus.tick1us};
    assign rise_s     = tick_s & ~tickQ_r;
    assign loadZero_s = (tmr.cfgLoad == '0);

    // Tick history for rising-edge detection.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tickQ_r <= 3'b000;
        end else begin
            tickQ_r <= tick_s;
        end
    end

    // Select the rise of the unit captured at start; reserved encoding counts microseconds.
    always_comb begin
        unitRise_s = 1'b0;
        case (unit_r)
            2'd1:    unitRise_s = rise_s[1];
            2'd2:    unitRise_s = rise_s[2];
            default: unitRise_s = rise_s[0];
        endcase
    end

    // Next-state logic; stop outranks start, which outranks a unit tick.
    always_comb begin
        stateNext_s    = state_r;
        countNext_s    = count_r;
        expireNext_s   = 1'b0;
        unitNext_s     = unit_r;
        periodicNext_s = periodic_r;
        if (tmr.stop) begin
            stateNext_s = StIdle;
        end else if (tmr.start) begin
            unitNext_s     = tmr.cfgUnit;
            periodicNext_s = tmr.cfgPeriodic;
            if (loadZero_s) begin
                countNext_s  = '0;
                expireNext_s = 1'b1;
                stateNext_s  = StIdle;
            end else begin
                countNext_s = tmr.cfgLoad;
                stateNext_s = StRun;
            end
        end else if ((state_r == StRun) && unitRise_s) begin
            if (count_r > One) begin
                countNext_s = count_r - One;
            end else begin
                expireNext_s = 1'b1;
                // A periodic reload of zero has nothing to count, so it ends like a one-shot.
                if (periodic_r && !loadZero_s) begin
                    countNext_s = tmr.cfgLoad;
                    stateNext_s = StRun;
                end else begin
                    countNext_s = '0;
                    stateNext_s = StIdle;
                end
            end
        end else begin
            stateNext_s = state_r;
        end
    end

    // Timer state and registered outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r    <= StIdle;
            unit_r     <= 2'd0;
            periodic_r <= 1'b0;
            count_r    <= '0;
            expire_r   <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            unit_r     <= unitNext_s;
            periodic_r <= periodicNext_s;
            count_r    <= countNext_s;
            expire_r   <= expireNext_s;
            running_r  <= (stateNext_s == StRun);
        end
    end

    // Tick-stream monitor: interval length of tick1us and ms/s alignment.
    always_comb begin
        usCntNext_s   = usCnt_r;
        intervalBad_s = 1'b0;
        if (rise_s[0]) begin
            usCntNext_s   = 16'd1;
            // A saturated counter never equals the nominal interval, so it is flagged here too.
            intervalBad_s = usSeen_r && (usCnt_r != UsNom) && (usCnt_r != UsNomP1);
        end else if (usCnt_r != CntMax) begin
            usCntNext_s = usCnt_r + 16'd1;
        end else begin
            usCntNext_s = CntMax;
        end
        alignBad_s = (rise_s[1] & ~rise_s[0]) | (rise_s[2] & ~rise_s[1]);
        if (intervalBad_s || alignBad_s) begin
            tickErrorNext_s = 1'b1;
        end else if (tmr.tickErrorClear) begin
            tickErrorNext_s = 1'b0;
        end else begin
            tickErrorNext_s = tickError_r;
        end
    end

    // Monitor registers; the first tick1us rise after reset only arms the interval check.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            usCnt_r     <= 16'd0;
            usSeen_r    <= 1'b0;
            tickError_r <= 1'b0;
        end else begin
            usCnt_r     <= usCntNext_s;
            usSeen_r    <= usSeen_r | rise_s[0];
            tickError_r <= tickErrorNext_s;
        end
    end

    assign tmr.running   = running_r;
    assign tmr.count     = count_r;
    assign tmr.expire    = expire_r;
    assign tmr.tickError = tickError_r;
endmodule

// File: tb/tb_oc_tick_timer.sv
// Directed bench for oc_tick_timer: expire events are queued at stimulus time and
// checked by an independent monitor; status values are checked after each tick period.
module tb_oc_tick_timer;
    localparam logic [3:0] CNone   = 4'b0000;
    localparam logic [3:0] CStart  = 4'b0001;
    localparam logic [3:0] CStop   = 4'b0010;
    localparam logic [3:0] CClear  = 4'b0100;
    localparam logic [3:0] CMsOnly = 4'b1000;

    typedef struct {
        int cycle;
        int cnt;
        int run;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetN;
    logic [2:0] ticks;
    int         cyc = 0;
    int         nCompared = 0;
    int         nFailed = 0;
    exp_t       expQ[$];

    oc_tick_timer_if #(.CountWidth(32)) tmr ();

    oc_tick_timer #(
        .ClockHz   (100_000_000),
        .CountWidth(32)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .chipStatus(ticks),
        .tmr       (tmr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expire monitor: every pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (resetN === 1'b1 && tmr.expire !== 1'b0) begin
            if (expQ.size() == 0) begin
                check("unexpected_expire", 32'(tmr.expire), 32'd0);
            end else begin
                e = expQ.pop_front();
                check("expire_cycle", cyc, e.cycle);
                check("expire_count", tmr.count, e.cnt);
                check("expire_running", 32'(tmr.running), e.run);
            end
        end
    end

    // One tick1us period: rise at offset 0 (with optional ms/s), control pulse at ctlAt.
    // pushAt 1 queues an expire caused by this rise, 2 one caused by the control pulse.
    task automatic pulse(input int period, input logic ms, input logic s, input int ctlAt,
                         input logic [3:0] ctl, input int pushAt, input int eCnt, input int eRun);
        for (int i = 0; i < period; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) begin
                ticks = {s, ms, 1'b1};
                if (pushAt == 1) expQ.push_back('{cycle: cyc + 1, cnt: eCnt, run: eRun});
            end
            if (i == 5) ticks = 3'b000;
            if (i == ctlAt) begin
                tmr.start          = ctl[0];
                tmr.stop           = ctl[1];
                tmr.tickErrorClear = ctl[2];
                if (ctl[3]) ticks[1] = 1'b1;
                if (pushAt == 2) expQ.push_back('{cycle: cyc + 1, cnt: eCnt, run: eRun});
            end else begin
                tmr.start          = 1'b0;
                tmr.stop           = 1'b0;
                tmr.tickErrorClear = 1'b0;
            end
            if (ctl[3] && i == ctlAt + 3) ticks[1] = 1'b0;
        end
    endtask

    task automatic plain(input int n);
        for (int k = 0; k < n; k++) pulse(100, 1'b0, 1'b0, -1, CNone, 0, 0, 0);
    endtask

    initial begin
        resetN             = 1'b0;
        ticks              = 3'b000;
        tmr.start          = 1'b0;
        tmr.stop           = 1'b0;
        tmr.tickErrorClear = 1'b0;
        tmr.cfgUnit        = 2'd0;
        tmr.cfgPeriodic    = 1'b0;
        tmr.cfgLoad        = 32'd0;
        #12;
        check("rst_running", 32'(tmr.running), 32'd0);
        check("rst_count", tmr.count, 32'd0);
        check("rst_expire", 32'(tmr.expire), 32'd0);
        check("rst_tickError", 32'(tmr.tickError), 32'd0);
        @(posedge clock);
        #3 resetN = 1'b1;

        plain(3);
        check("warm_tickError", 32'(tmr.tickError), 32'd0);

        // us one-shot, load 3
        tmr.cfgUnit = 2'd0; tmr.cfgLoad = 32'd3; tmr.cfgPeriodic = 1'b0;
        pulse(100, 1'b0, 1'b0, 10, CStart, 0, 0, 0);
        check("os_running", 32'(tmr.running), 32'd1);
        check("os_count3", tmr.count, 32'd3);
        plain(1);
        check("os_count2", tmr.count, 32'd2);
        plain(1);
        check("os_count1", tmr.count, 32'd1);
        pulse(100, 1'b0, 1'b0, -1, CNone, 1, 0, 0);
        check("os_done_running", 32'(tmr.running), 32'd0);
        check("os_done_count", tmr.count, 32'd0);

        // ms periodic, load 2 (ms ticks every 4th us tick, compressed)
        tmr.cfgUnit = 2'd1; tmr.cfgLoad = 32'd2; tmr.cfgPeriodic = 1'b1;
        pulse(100, 1'b0, 1'b0, 10, CStart, 0, 0, 0);
        check("per_count_start", tmr.count, 32'd2);
        for (int k = 0; k < 2; k++) begin
            plain(3);
            check("per_us_ignored", tmr.count, 32'd2);
            pulse(100, 1'b1, 1'b0, -1, CNone, 0, 0, 0);
            check("per_count1", tmr.count, 32'd1);
            plain(3);
            pulse(100, 1'b1, 1'b0, -1, CNone, 1, 2, 1);
            check("per_reload", tmr.count, 32'd2);
            check("per_running", 32'(tmr.running), 32'd1);
        end
        tmr.cfgUnit = 2'd0;
        plain(1);
        check("per_unit_latched", tmr.count, 32'd2);
        pulse(100, 1'b0, 1'b0, 10, CStop, 0, 0, 0);
        check("per_stop_running", 32'(tmr.running), 32'd0);
        check("per_stop_count", tmr.count, 32'd2);

        // start with load 0
        tmr.cfgLoad = 32'd0; tmr.cfgPeriodic = 1'b0;
        pulse(100, 1'b0, 1'b0, 10, CStart, 2, 0, 0);
        check("zero_running", 32'(tmr.running), 32'd0);

        // stop with a same-cycle tick at count 5
        tmr.cfgLoad = 32'd5;
        pulse(100, 1'b0, 1'b0, 10, CStart, 0, 0, 0);
        check("stop_pre_count", tmr.count, 32'd5);
        pulse(100, 1'b0, 1'b0, 0, CStop, 0, 0, 0);
        check("stop_count", tmr.count, 32'd5);
        check("stop_running", 32'(tmr.running), 32'd0);
        plain(1);
        check("stop_idle_hold", tmr.count, 32'd5);

        // restart while running with a same-cycle tick
        tmr.cfgLoad = 32'd7;
        pulse(100, 1'b0, 1'b0, 10, CStart, 0, 0, 0);
        check("restart_pre", tmr.count, 32'd7);
        tmr.cfgLoad = 32'd9;
        pulse(100, 1'b0, 1'b0, 0, CStart, 0, 0, 0);
        check("restart_count", tmr.count, 32'd9);
        check("restart_running", 32'(tmr.running), 32'd1);
        plain(1);
        check("restart_dec", tmr.count, 32'd8);

        // periodic reload of zero ends the run
        tmr.cfgLoad = 32'd1; tmr.cfgPeriodic = 1'b1;
        pulse(100, 1'b0, 1'b0, 10, CStart, 0, 0, 0);
        check("rz_count", tmr.count, 32'd1);
        tmr.cfgLoad = 32'd0;
        pulse(100, 1'b0, 1'b0, -1, CNone, 1, 0, 0);
        check("rz_running", 32'(tmr.running), 32'd0);
        check("rz_count0", tmr.count, 32'd0);

        // tick-stream checker
        check("err_clean", 32'(tmr.tickError), 32'd0);
        pulse(102, 1'b0, 1'b0, -1, CNone, 0, 0, 0);
        plain(1);
        check("err_interval102", 32'(tmr.tickError), 32'd1);
        pulse(100, 1'b0, 1'b0, 10, CClear, 0, 0, 0);
        check("err_clear1", 32'(tmr.tickError), 32'd0);
        pulse(100, 1'b0, 1'b0, 50, CMsOnly, 0, 0, 0);
        check("err_ms_align", 32'(tmr.tickError), 32'd1);
        pulse(100, 1'b0, 1'b0, 10, CClear, 0, 0, 0);
        check("err_clear2", 32'(tmr.tickError), 32'd0);
        pulse(100, 1'b0, 1'b0, -1, CNone, 0, 0, 0);
        pulse(101, 1'b0, 1'b0, -1, CNone, 0, 0, 0);
        pulse(100, 1'b0, 1'b0, -1, CNone, 0, 0, 0);
        pulse(101, 1'b0, 1'b0, -1, CNone, 0, 0, 0);
        plain(1);
        check("err_good_intervals", 32'(tmr.tickError), 32'd0);
        pulse(100, 1'b0, 1'b1, -1, CNone, 0, 0, 0);
        check("err_s_align", 32'(tmr.tickError), 32'd1);

        // async reset mid-run
        tmr.cfgLoad = 32'd50; tmr.cfgPeriodic = 1'b0;
        pulse(100, 1'b0, 1'b0, 10, CStart, 0, 0, 0);
        plain(2);
        check("mid_count", tmr.count, 32'd48);
        #2 resetN = 1'b0;
        #1;
        check("arst_running", 32'(tmr.running), 32'd0);
        check("arst_count", tmr.count, 32'd0);
        check("arst_expire", 32'(tmr.expire), 32'd0);
        check("arst_tickError", 32'(tmr.tickError), 32'd0);
        repeat (3) @(posedge clock);
        #3 resetN = 1'b1;
        repeat (37) @(posedge clock);
        plain(3);
        check("post_rst_tickError", 32'(tmr.tickError), 32'd0);
        check("post_rst_running", 32'(tmr.running), 32'd0);

        check("exp_queue_empty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule
